// File: rtl/rrf.sv
// Retirement register file: committed arch->phys map, per-lane release of the
// displaced physical register, and the restore map for the rename RAT.
// Optional consistency checker enabled by defining RRF_CHECK_EN (adds dbg_err).

module rrf_lane #(
    parameter int ARF_DEPTH = 32,
    parameter int ARF_IDX   = 5,
    parameter int PRF_DEPTH = 64,
    parameter int PRF_IDX   = 6
) (
    input  logic                                 active,
    input  logic [ARF_IDX-1:0]                   rd_arch,
    input  logic [PRF_IDX-1:0]                   rd_phy,
    input  logic [ARF_DEPTH-1:0][PRF_IDX-1:0]    map_in,
    output logic [ARF_DEPTH-1:0][PRF_IDX-1:0]    map_out,
    output logic                                 free_valid,
    output logic [PRF_IDX-1:0]                   free_phy
`ifdef RRF_CHECK_EN
    ,
    input  logic [PRF_DEPTH-1:0]                 mapped_in,
    output logic [PRF_DEPTH-1:0]                 mapped_out,
    output logic                                 err
`endif
);
    logic [PRF_IDX-1:0] old;

    assign old = map_in[rd_arch];

    always_comb begin
        map_out    = map_in;
        free_valid = 1'b0;
        free_phy   = '0;
        if (active) begin
            free_valid       = 1'b1;
            free_phy         = old;
            map_out[rd_arch] = rd_phy;
        end
    end

`ifdef RRF_CHECK_EN
    // A new destination must be unmapped and the displaced one must be mapped.
    always_comb begin
        mapped_out = mapped_in;
        err        = 1'b0;
        if (active) begin
            err                = mapped_in[rd_phy] | ~mapped_in[old];
            mapped_out[old]    = 1'b0;
            mapped_out[rd_phy] = 1'b1;
        end
    end
`endif

endmodule

module rrf #(
    parameter int ID_WIDTH  = 2,
    parameter int ARF_DEPTH = 32,
    parameter int ARF_IDX   = 5,
    parameter int PRF_DEPTH = 64,
    parameter int PRF_IDX   = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ID_WIDTH-1:0]                  commit_valid,
    input  logic [ID_WIDTH-1:0][PRF_IDX-1:0]     commit_rd_phy,
    input  logic [ID_WIDTH-1:0][ARF_IDX-1:0]     commit_rd_arch,
    input  logic                                 backend_flush,
    output logic [ID_WIDTH-1:0]                  free_valid,
    output logic [ID_WIDTH-1:0][PRF_IDX-1:0]     free_phy,
    output logic [ARF_DEPTH-1:0][PRF_IDX-1:0]    restore_map
`ifdef RRF_CHECK_EN
    ,
    output logic                                 dbg_err
`endif
);
    logic [ARF_DEPTH-1:0][PRF_IDX-1:0] map_q;
    logic [ARF_DEPTH-1:0][PRF_IDX-1:0] map_chain [ID_WIDTH+1];
    logic [ID_WIDTH-1:0]               lane_active;

    // Flush never touches committed state; reset discards any in-flight commit.
    logic flush_unused;
    assign flush_unused = backend_flush;

    assign map_chain[0] = map_q;

`ifdef RRF_CHECK_EN
    logic [PRF_DEPTH-1:0] mapped_q;
    logic [PRF_DEPTH-1:0] mapped_chain [ID_WIDTH+1];
    logic [ID_WIDTH-1:0]  lane_err;

    assign mapped_chain[0] = mapped_q;
`endif

    for (genvar i = 0; i < ID_WIDTH; i++) begin : g_lane
        assign lane_active[i] = ~rst & commit_valid[i] & (commit_rd_arch[i] != '0);

        rrf_lane #(
            .ARF_DEPTH (ARF_DEPTH),
            .ARF_IDX   (ARF_IDX),
            .PRF_DEPTH (PRF_DEPTH),
            .PRF_IDX   (PRF_IDX)
        ) u_lane (
            .active     (lane_active[i]),
            .rd_arch    (commit_rd_arch[i]),
            .rd_phy     (commit_rd_phy[i]),
            .map_in     (map_chain[i]),
            .map_out    (map_chain[i+1]),
            .free_valid (free_valid[i]),
            .free_phy   (free_phy[i])
`ifdef RRF_CHECK_EN
            ,
            .mapped_in  (mapped_chain[i]),
            .mapped_out (mapped_chain[i+1]),
            .err        (lane_err[i])
`endif
        );
    end

    assign restore_map = map_chain[ID_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARF_DEPTH; i++)
                map_q[i] <= PRF_IDX'(i);
        end else begin
            map_q <= map_chain[ID_WIDTH];
        end
    end

`ifdef RRF_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PRF_DEPTH; i++)
                mapped_q[i] <= (i < ARF_DEPTH);
            dbg_err <= 1'b0;
        end else begin
            mapped_q <= mapped_chain[ID_WIDTH];
            dbg_err  <= dbg_err | (|lane_err);
`ifndef SYNTHESIS
            if (|lane_err)
                $error("rrf: inconsistent commit, lane_err=%b", lane_err);
`endif
        end
    end
`endif

endmodule
